// File: rtl/obs_overlap_mac.sv
// Purpose: interleave the four OBS odd/even sub-products into one carry-less product and XOR-accumulate.
// Latency: 1 cycle from the accepted last beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls every beat, last or not.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   in_valid/in_ready           input handshake; in_p_ee/eo/oe/oo are the P-bit sub-products
//   in_last                     beat closes the current accumulation and produces a result
//   clr                         drop the partial accumulation (the beat accepted with it becomes term 1)
//   out_valid/out_ready         result handshake
//   out_data                    W = 2P+1 bit accumulated carry-less product
//   out_terms, out_ovf          saturating term count and its saturation flag
module obs_overlap_mac #(
    parameter  int P    = 93,
    parameter  int CNTW = 8,
    localparam int W    = 2 * P + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [P-1:0]    in_p_ee,
    input  logic [P-1:0]    in_p_eo,
    input  logic [P-1:0]    in_p_oe,
    input  logic [P-1:0]    in_p_oo,
    input  logic            in_last,
    input  logic            clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [CNTW-1:0] out_terms,
    output logic            out_ovf
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [W-1:0]    acc;
    logic [CNTW-1:0] cnt;
    logic            sat;

    logic [W-1:0]    r;
    logic [W-1:0]    sum;
    logic [CNTW-1:0] base_cnt;
    logic [CNTW-1:0] n;
    logic            wrap;
    logic            sat_n;
    logic            accept;

    // Even result bits overlap ee[i] with oo[i-1]; odd bits are the two cross terms.
    always_comb begin
        r    = '0;
        r[0] = in_p_ee[0];
        for (int i = 1; i < P; i++) begin
            r[2*i] = in_p_ee[i] ^ in_p_oo[i-1];
        end
        r[2*P] = in_p_oo[P-1];
        for (int i = 0; i < P; i++) begin
            r[2*i+1] = in_p_eo[i] ^ in_p_oe[i];
        end
    end

    // Downstream readiness feeds straight through to the input side.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // clr on an accepted beat restarts from that beat as the first term.
    assign sum      = (clr ? '0 : acc) ^ r;
    assign base_cnt = clr ? '0 : cnt;
    assign wrap     = (base_cnt == CNT_MAX);
    assign n        = wrap ? CNT_MAX : base_cnt + 1'b1;
    assign sat_n    = (clr ? 1'b0 : sat) | wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_terms <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // Drop the current result once taken; a last beat accepted in the
            // same cycle overrides this below and keeps out_valid high.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    out_data  <= sum;
                    out_terms <= n;
                    out_ovf   <= sat_n;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sat       <= 1'b0;
                end else begin
                    acc <= sum;
                    cnt <= n;
                    sat <= sat_n;
                end
            end else if (clr) begin
                acc <= '0;
                cnt <= '0;
                sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_obs_overlap_mac.sv
module tb_obs_overlap_mac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ee = '0, eo = '0, oe = '0, oo = '0;
    logic       in_last = 1'b0, clr = 1'b0;

    // Main instance, CNTW = 8
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
    logic [6:0] out_data;
    logic [7:0] out_terms;

    // Saturation instance, CNTW = 2
    logic       in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, out_ovf2;
    logic [6:0] out_data2;
    logic [1:0] out_terms2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    obs_overlap_mac #(.P(3), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p_ee(ee), .in_p_eo(eo), .in_p_oe(oe), .in_p_oo(oo),
        .in_last(in_last), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_terms(out_terms), .out_ovf(out_ovf)
    );

    obs_overlap_mac #(.P(3), .CNTW(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_p_ee(ee), .in_p_eo(eo), .in_p_oe(oe), .in_p_oo(oo),
        .in_last(in_last), .clr(clr),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_terms(out_terms2), .out_ovf(out_ovf2)
    );

    task automatic set_beat(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                            input logic [2:0] d, input logic last, input logic c_clr);
        ee = a; eo = b; oe = c; oo = d; in_last = last; clr = c_clr;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_valid2 = 1'b0;
        set_beat(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== 7'h00) begin fails++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        tests++; if (out_terms !== 8'd0) begin fails++; $display("FAIL reset_out_terms: got %0d expected 0", out_terms); end
        tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        rst_n = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_term();
        out_ready = 1'b1;
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        tests++; if (out_data !== 7'h49) begin fails++; $display("FAIL single_data: got %h expected 49", out_data); end
        tests++; if (out_terms !== 8'd1) begin fails++; $display("FAIL single_terms: got %0d expected 1", out_terms); end
        tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL single_ovf: got %b expected 0", out_ovf); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_accumulate();
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL acc_no_early_result: got %b expected 0", out_valid); end
        set_beat(3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        tick();
        idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL acc_valid: got %b expected 1", out_valid); end
        tests++; if (out_data !== 7'h48) begin fails++; $display("FAIL acc_data: got %h expected 48", out_data); end
        tests++; if (out_terms !== 8'd2) begin fails++; $display("FAIL acc_terms: got %0d expected 2", out_terms); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL acc_one_result: got %b expected 0", out_valid); end
    endtask

    task automatic test_clr();
        // clr alone between beats
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_beat(3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        idle();
        tests++; if (out_data !== 7'h01) begin fails++; $display("FAIL clr_idle_data: got %h expected 01", out_data); end
        tests++; if (out_terms !== 8'd1) begin fails++; $display("FAIL clr_idle_terms: got %0d expected 1", out_terms); end
        // clr on the accepted beat: that beat is term 1
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        set_beat(3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
        tick();
        idle();
        tests++; if (out_data !== 7'h01) begin fails++; $display("FAIL clr_beat_data: got %h expected 01", out_data); end
        tests++; if (out_terms !== 8'd1) begin fails++; $display("FAIL clr_beat_terms: got %0d expected 1", out_terms); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        set_beat(3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
        tests++; if (out_data !== 7'h49) begin fails++; $display("FAIL bp_hold_data: got %h expected 49", out_data); end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_high: got %b expected 1", in_ready); end
        tick();
        idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
        tests++; if (out_data !== 7'h01) begin fails++; $display("FAIL bp_next_data: got %h expected 01", out_data); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_tab [8];
        exp_tab = '{7'h00, 7'h01, 7'h04, 7'h05, 7'h10, 7'h11, 7'h14, 7'h15};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_beat(3'(i), 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin
                fails++; $display("FAIL stream_%0d: got valid %b data %h expected valid 1 data %h", i, out_valid, out_data, exp_tab[i]);
            end
        end
        idle();
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [2:0] s_ee [5];
        logic [2:0] s_eo [5];
        logic [2:0] s_oo [5];
        // R values 01, 04, 10, 40, 02 -> XOR 57
        s_ee = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        s_eo = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        s_oo = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_beat(s_ee[i], s_eo[i], 3'b000, s_oo[i], (i == 4), 1'b0);
            tick();
        end
        idle();
        tests++; if (out_valid2 !== 1'b1) begin fails++; $display("FAIL sat_valid: got %b expected 1", out_valid2); end
        tests++; if (out_data2 !== 7'h57) begin fails++; $display("FAIL sat_data: got %h expected 57", out_data2); end
        tests++; if (out_terms2 !== 2'd3) begin fails++; $display("FAIL sat_terms: got %0d expected 3", out_terms2); end
        tests++; if (out_ovf2 !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b expected 1", out_ovf2); end
        tick();
    endtask

    task automatic test_async_reset();
        // dut holds a pending result; dut_s is mid-accumulation
        out_ready  = 1'b0;
        out_ready2 = 1'b1;
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        idle();
        set_beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b0, 1'b0);
        in_valid2 = 1'b1;
        tick();
        tick();
        idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_pending: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_data !== 7'h00 || out_terms !== 8'd0 || out_ovf !== 1'b0) begin
            fails++; $display("FAIL rst_async_dut: got valid %b data %h terms %0d ovf %b expected all 0", out_valid, out_data, out_terms, out_ovf);
        end
        tests++; if (out_valid2 !== 1'b0 || out_data2 !== 7'h00 || out_terms2 !== 2'd0 || out_ovf2 !== 1'b0) begin
            fails++; $display("FAIL rst_async_sat: got valid %b data %h terms %0d ovf %b expected all 0", out_valid2, out_data2, out_terms2, out_ovf2);
        end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        // partial sum must be gone
        set_beat(3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        in_valid2 = 1'b1;
        tick();
        idle();
        tests++; if (out_data2 !== 7'h01 || out_terms2 !== 2'd1 || out_ovf2 !== 1'b0) begin
            fails++; $display("FAIL rst_partial_lost: got data %h terms %0d ovf %b expected 01 1 0", out_data2, out_terms2, out_ovf2);
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_pending_lost: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_term();
        test_accumulate();
        test_clr();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
